// File: rtl/iic_bit_phy.sv
// Bit-level I2C PHY: executes one START/STOP/WRITE_BIT/READ_BIT symbol per 5L-cycle period
// and drives registered SCL/SDA pins (SDA through a tri-state pad).
module iic_bit_phy #(
    parameter int unsigned SYS_CLK_KHZ = 200000,
    parameter int unsigned I2C_BPS     = 100000,
    parameter bit          OPEN_DRAIN  = 1'b0
) (
    input  logic       sys_clk,
    input  logic       sys_nrst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    input  logic       wr_bit,
    output logic       cmd_ready,
    output logic       done,
    output logic       rd_bit,
    output logic       busy,
    output logic       scl,
    inout  wire        sda
);

    localparam int unsigned L      = 32'((64'(SYS_CLK_KHZ) * 64'd1000) / 64'(I2C_BPS) / 64'd5);
    localparam int unsigned Period = 5 * L;
    localparam int unsigned CntW   = $clog2(Period);

    localparam logic [CntW-1:0] CntL    = CntW'(L);
    localparam logic [CntW-1:0] Cnt2L   = CntW'(2 * L);
    localparam logic [CntW-1:0] Cnt3L   = CntW'(3 * L);
    localparam logic [CntW-1:0] Cnt4L   = CntW'(4 * L);
    localparam logic [CntW-1:0] CntLast = CntW'(Period - 1);

    if (L < 4) begin : g_phase_check
        $error("iic_bit_phy: phase unit L = %0d, must be at least 4", L);
    end

    typedef enum logic [2:0] {StIdle, StStart, StStop, StWbit, StRbit} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wbit_q, wbit_d;
    logic            done_q, done_d;
    logic            scl_q, scl_d;
    logic            sda_q, sda_d;
    logic            sda_oe_q, sda_oe_d;
    logic            sda_meta_q, sda_sync_q;
    logic            rd_bit_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wbit_d  = wbit_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    cnt_d  = '0;
                    wbit_d = wr_bit;
                    unique case (cmd)
                        2'd0:    state_d = StStart;
                        2'd1:    state_d = StStop;
                        2'd2:    state_d = StWbit;
                        default: state_d = StRbit;
                    endcase
                end
            end
            default: begin
                if (cnt_q == CntLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        endcase
    end

    // Pins are computed from the next state/count so pin edges line up with cnt values.
    always_comb begin
        scl_d = scl_q;
        sda_d = sda_q;
        unique case (state_d)
            StStart: begin
                if (cnt_d == '0) begin
                    scl_d = 1'b1;
                    sda_d = 1'b1;
                end else if (cnt_d == CntL) begin
                    sda_d = 1'b0;
                end else if (cnt_d == Cnt4L) begin
                    scl_d = 1'b0;
                end
            end
            StStop: begin
                if (cnt_d == '0) begin
                    scl_d = 1'b0;
                    sda_d = 1'b0;
                end else if (cnt_d == CntL) begin
                    scl_d = 1'b1;
                end else if (cnt_d == Cnt4L) begin
                    sda_d = 1'b1;
                end
            end
            StWbit, StRbit: begin
                if (state_d == StWbit) begin
                    sda_d = wbit_d;
                end
                if (cnt_d == '0) begin
                    scl_d = 1'b0;
                end else if (cnt_d == CntL) begin
                    scl_d = 1'b1;
                end else if (cnt_d == Cnt3L) begin
                    scl_d = 1'b0;
                end
            end
            default: ;
        endcase
        sda_oe_d = (state_d != StRbit) && (!OPEN_DRAIN || !sda_d);
    end

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            wbit_q     <= 1'b0;
            done_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            sda_oe_q   <= !OPEN_DRAIN;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            rd_bit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wbit_q     <= wbit_d;
            done_q     <= done_d;
            scl_q      <= scl_d;
            sda_q      <= sda_d;
            sda_oe_q   <= sda_oe_d;
            sda_meta_q <= sda;
            sda_sync_q <= sda_meta_q;
            if (state_q == StRbit && cnt_q == Cnt2L) begin
                rd_bit_q <= sda_sync_q;
            end
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = !cmd_ready;
    assign done      = done_q;
    assign rd_bit    = rd_bit_q;
    assign scl       = scl_q;
    assign sda       = sda_oe_q ? (OPEN_DRAIN ? 1'b0 : sda_q) : 1'bz;

endmodule

// File: tb/tb_iic_bit_phy.sv
// Bench for iic_bit_phy: scoreboard of issued symbols checked per cycle against a pin model,
// plus a second open-drain instance exercised directly.
module tb_iic_bit_phy;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    always #5 clk = ~clk;

    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic       wr_bit = 1'b0;
    logic       cmd_ready, done, rd_bit, busy, scl;
    wire        sda;
    logic       tb_sda_low = 1'b0;
    assign sda = tb_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    logic       cmd_valid_od = 1'b0;
    logic [1:0] cmd_od = 2'd0;
    logic       wr_bit_od = 1'b0;
    logic       cmd_ready_od, done_od, rd_bit_od, busy_od, scl_od;
    wire        sda_od;
    logic       tb_od_low = 1'b0;
    assign sda_od = tb_od_low ? 1'b0 : 1'bz;
    pullup (sda_od);

    iic_bit_phy #(.SYS_CLK_KHZ(1000), .I2C_BPS(50000), .OPEN_DRAIN(1'b0)) u_dut (
        .sys_clk  (clk),
        .sys_nrst (nrst),
        .cmd_valid(cmd_valid),
        .cmd      (cmd),
        .wr_bit   (wr_bit),
        .cmd_ready(cmd_ready),
        .done     (done),
        .rd_bit   (rd_bit),
        .busy     (busy),
        .scl      (scl),
        .sda      (sda)
    );

    iic_bit_phy #(.SYS_CLK_KHZ(1000), .I2C_BPS(50000), .OPEN_DRAIN(1'b1)) u_dut_od (
        .sys_clk  (clk),
        .sys_nrst (nrst),
        .cmd_valid(cmd_valid_od),
        .cmd      (cmd_od),
        .wr_bit   (wr_bit_od),
        .cmd_ready(cmd_ready_od),
        .done     (done_od),
        .rd_bit   (rd_bit_od),
        .busy     (busy_od),
        .scl      (scl_od),
        .sda      (sda_od)
    );

    typedef struct {
        logic [1:0] c;
        logic       wb;
        logic       rexp;
        int         acc;
    } rec_t;

    rec_t q[$];
    int   cyc = 0;
    int   free_cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    logic mon_en = 1'b0;
    logic model_rd = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Called at a negedge; accepted on the following posedge once the model says idle.
    task automatic issue(input logic [1:0] c, input logic wb, input logic rd);
        rec_t r;
        while (cyc < free_cyc) @(negedge clk);
        if (c == 2'd3) model_rd = rd;
        cmd_valid = 1'b1;
        cmd       = c;
        wr_bit    = wb;
        r.c = c;
        r.wb = wb;
        r.rexp = model_rd;
        r.acc = cyc + 1;
        q.push_back(r);
        free_cyc = cyc + 21;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("sb_drained", q.size(), 0);
    endtask

    always @(negedge clk) begin
        logic exp_done, act, ec, es;
        int   k;
        rec_t r;
        if (mon_en) begin
            exp_done = (q.size() > 0) && (cyc == q[0].acc + 20);
            check_eq("done", done, exp_done);
            if (exp_done) begin
                check_eq("rd_bit_at_done", rd_bit, q[0].rexp);
                check_eq("ready_at_done", cmd_ready, 1);
                void'(q.pop_front());
            end
            act = 1'b0;
            if (q.size() > 0 && cyc >= q[0].acc && cyc < q[0].acc + 20) begin
                act = 1'b1;
                r = q[0];
                k = cyc - r.acc;
                ec = 1'b0;
                es = 1'b0;
                case (r.c)
                    2'd0: begin ec = (k < 16); es = (k < 4); end
                    2'd1: begin ec = (k >= 4); es = (k >= 16); end
                    2'd2: begin ec = (k >= 4 && k < 12); es = r.wb; end
                    default: begin ec = (k >= 4 && k < 12); es = !tb_sda_low; end
                endcase
                check_eq($sformatf("scl cmd=%0d k=%0d", r.c, k), scl, ec);
                check_eq($sformatf("sda cmd=%0d k=%0d", r.c, k), sda, es);
            end
            check_eq("busy", busy, act);
            check_eq("cmd_ready", cmd_ready, !act);
        end
    end

    task automatic od_write(input logic wb);
        int acc_od;
        cmd_valid_od = 1'b1;
        cmd_od       = 2'd2;
        wr_bit_od    = wb;
        acc_od       = cyc + 1;
        @(negedge clk);
        cmd_valid_od = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("od_scl_high", scl_od, 1);
        if (wb) begin
            tb_od_low = 1'b1;
            #1;
            check_eq("od_w1_released_pulled_low", sda_od, 0);
            tb_od_low = 1'b0;
            #1;
            check_eq("od_w1_pullup", sda_od, 1);
        end else begin
            check_eq("od_w0_driven_low", sda_od, 0);
        end
        while (cyc < acc_od + 20) @(negedge clk);
        check_eq("od_done", done_od, 1);
        check_eq("od_ready_at_done", cmd_ready_od, 1);
        check_eq("od_busy_at_done", busy_od, 0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_scl", scl, 1);
        check_eq("rst_sda", sda, 1);
        nrst = 1'b1;
        @(negedge clk);
        check_eq("init_scl", scl, 1);
        check_eq("init_sda", sda, 1);
        check_eq("init_ready", cmd_ready, 1);
        check_eq("init_busy", busy, 0);
        check_eq("init_done", done, 0);
        check_eq("init_rd_bit", rd_bit, 0);
        check_eq("od_init_scl", scl_od, 1);
        check_eq("od_init_sda_pullup", sda_od, 1);
        tb_od_low = 1'b1;
        #1;
        check_eq("od_init_sda_released", sda_od, 0);
        tb_od_low = 1'b0;

        free_cyc = cyc;
        mon_en   = 1'b1;
        issue(2'd0, 1'b0, 1'b0);
        issue(2'd2, 1'b1, 1'b0);
        issue(2'd2, 1'b0, 1'b0);
        wait_idle();

        tb_sda_low = 1'b1;
        issue(2'd3, 1'b0, 1'b0);
        wait_idle();
        tb_sda_low = 1'b0;
        issue(2'd3, 1'b0, 1'b1);
        wait_idle();

        // STOP while a spurious START request is held during busy.
        issue(2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd       = 2'd0;
            wr_bit    = 1'b1;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle();

        // Reset in the middle of a WRITE_BIT 0 while SCL is high.
        issue(2'd2, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        mon_en = 1'b0;
        #1;
        nrst = 1'b0;
        #1;
        check_eq("midrst_scl", scl, 1);
        check_eq("midrst_sda", sda, 1);
        check_eq("midrst_ready", cmd_ready, 1);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_rd_bit", rd_bit, 0);
        q.delete();
        model_rd = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        free_cyc = cyc;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        issue(2'd2, 1'b1, 1'b0);
        wait_idle();

        od_write(1'b1);
        od_write(1'b0);
        check_eq("od_rd_bit", rd_bit_od, 0);

        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
